disp_param_sched: RTL

Frame-synchronous scheduler for the receiver card's display-parameter set (brightness, gamma, colour temperature, M4 mode, output channel). It arbitrates parameter writes from three requesters: the network control-packet decoder, the local command port and the M4 preset engine. Accepted writes go into a shadow bank. The shadow bank is copied to the active outputs only on an OVP frame strobe, so the scan datapath never changes parameters mid-frame. It sits between the control-packet/command sources and the gamma/brightness pipeline, next to the OVP/freeze logic.

---
 rtl/disp_param_sched_if.sv | 11 +
 rtl/disp_param_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/disp_param_sched_if.sv
// Write-request bundle for one parameter requester.
// The requester drives req/addr/data; the scheduler returns a one-cycle ack.
interface disp_param_sched_if;
    logic       req;
    logic [2:0] addr;
    logic [7:0] data;
    logic       ack;

    modport master (output req, output addr, output data, input ack);
    modport slave  (input req, input addr, input data, output ack);
endinterface

// File: rtl/disp_param_sched.sv
// Frame-synchronous display-parameter scheduler.
// Three requesters (net, cmd, m4) are served round-robin into a shadow bank.
// The shadow bank is copied to the active outputs only on an unfrozen OVP strobe,
// so the scan datapath never sees a parameter change mid-frame.
module disp_param_sched (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ovp,
    input  logic                      i_freeze,
    disp_param_sched_if.slave         net_if,
    disp_param_sched_if.slave         cmd_if,
    disp_param_sched_if.slave         m4_if,
    output logic [6:0]                o_brightness,
    output logic [2:0]                o_gamma,
    output logic [3:0]                o_ct_red,
    output logic [3:0]                o_ct_green,
    output logic [3:0]                o_ct_blue,
    output logic                      o_m4_on,
    output logic                      o_m4_bank1,
    output logic [2:0]                o_out_ch,
    output logic                      o_param_update,
    output logic                      o_dirty,
    output logic                      o_addr_err
);

    localparam logic [6:0] RST_BRIGHT = 7'h40;
    localparam logic [2:0] RST_GAMMA  = 3'd2;
    localparam logic [3:0] RST_CT     = 4'd8;
    localparam logic [1:0] RST_M4     = 2'b00;
    localparam logic [2:0] RST_OUTCH  = 3'd0;

    // Requester index: 0 = net, 1 = cmd, 2 = m4
    logic [1:0] r_ptr;
    logic [2:0] r_ack;
    logic       r_addr_err;
    logic       r_dirty;
    logic       r_param_update;

    logic [6:0] r_sh_bright, r_act_bright;
    logic [2:0] r_sh_gamma,  r_act_gamma;
    logic [3:0] r_sh_red,    r_act_red;
    logic [3:0] r_sh_green,  r_act_green;
    logic [3:0] r_sh_blue,   r_act_blue;
    logic [1:0] r_sh_m4,     r_act_m4;
    logic [2:0] r_sh_outch,  r_act_outch;

    logic [2:0] w_req;
    logic [2:0] w_elig;
    logic [2:0] w_gnt;
    logic [2:0] w_gnt_addr;
    logic [7:0] w_gnt_data;
    logic       w_wr;
    logic       w_err;
    logic       w_commit;

    assign w_req  = {m4_if.req, cmd_if.req, net_if.req};
    // A requester being acked this cycle sits out, so a held req is not double-counted
    assign w_elig = w_req & ~r_ack;

    // Round-robin pick: search begins with the requester after the last grant
    always_comb begin
        w_gnt = 3'b000;
        case (r_ptr)
            2'd0: begin
                if      (w_elig[1]) w_gnt = 3'b010;
                else if (w_elig[2]) w_gnt = 3'b100;
                else if (w_elig[0]) w_gnt = 3'b001;
            end
            2'd1: begin
                if      (w_elig[2]) w_gnt = 3'b100;
                else if (w_elig[0]) w_gnt = 3'b001;
                else if (w_elig[1]) w_gnt = 3'b010;
            end
            default: begin
                if      (w_elig[0]) w_gnt = 3'b001;
                else if (w_elig[1]) w_gnt = 3'b010;
                else if (w_elig[2]) w_gnt = 3'b100;
            end
        endcase
    end

    // Route the granted requester's address and data to the shadow write port
    always_comb begin
        w_gnt_addr = 3'd0;
        w_gnt_data = 8'd0;
        if (w_gnt[0]) begin
            w_gnt_addr = net_if.addr;
            w_gnt_data = net_if.data;
        end else if (w_gnt[1]) begin
            w_gnt_addr = cmd_if.addr;
            w_gnt_data = cmd_if.data;
        end else if (w_gnt[2]) begin
            w_gnt_addr = m4_if.addr;
            w_gnt_data = m4_if.data;
        end
    end

    assign w_wr     = (|w_gnt) && (w_gnt_addr != 3'd7);
    assign w_err    = (|w_gnt) && (w_gnt_addr == 3'd7);
    assign w_commit = i_ovp && !i_freeze && r_dirty;

    // Arbiter state: last-granted pointer, per-requester ack and reserved-address flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= 2'd2;
            r_ack      <= 3'b000;
            r_addr_err <= 1'b0;
        end else begin
            r_ack      <= w_gnt;
            r_addr_err <= w_err;
            if (w_gnt[0])      r_ptr <= 2'd0;
            else if (w_gnt[1]) r_ptr <= 2'd1;
            else if (w_gnt[2]) r_ptr <= 2'd2;
        end
    end

    // Shadow bank: takes the granted write; unused data bits are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_bright <= RST_BRIGHT;
            r_sh_gamma  <= RST_GAMMA;
            r_sh_red    <= RST_CT;
            r_sh_green  <= RST_CT;
            r_sh_blue   <= RST_CT;
            r_sh_m4     <= RST_M4;
            r_sh_outch  <= RST_OUTCH;
        end else if (w_wr) begin
            case (w_gnt_addr)
                3'd0:    r_sh_bright <= w_gnt_data[6:0];
                3'd1:    r_sh_gamma  <= w_gnt_data[2:0];
                3'd2:    r_sh_red    <= w_gnt_data[3:0];
                3'd3:    r_sh_green  <= w_gnt_data[3:0];
                3'd4:    r_sh_blue   <= w_gnt_data[3:0];
                3'd5:    r_sh_m4     <= w_gnt_data[1:0];
                default: r_sh_outch  <= w_gnt_data[2:0];
            endcase
        end
    end

    // Active bank and frame flags; a write landing on the commit edge keeps dirty set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act_bright   <= RST_BRIGHT;
            r_act_gamma    <= RST_GAMMA;
            r_act_red      <= RST_CT;
            r_act_green    <= RST_CT;
            r_act_blue     <= RST_CT;
            r_act_m4       <= RST_M4;
            r_act_outch    <= RST_OUTCH;
            r_dirty        <= 1'b0;
            r_param_update <= 1'b0;
        end else begin
            r_param_update <= w_commit;
            if (w_commit) begin
                r_act_bright <= r_sh_bright;
                r_act_gamma  <= r_sh_gamma;
                r_act_red    <= r_sh_red;
                r_act_green  <= r_sh_green;
                r_act_blue   <= r_sh_blue;
                r_act_m4     <= r_sh_m4;
                r_act_outch  <= r_sh_outch;
            end
            if (w_wr)          r_dirty <= 1'b1;
            else if (w_commit) r_dirty <= 1'b0;
        end
    end

    assign net_if.ack     = r_ack[0];
    assign cmd_if.ack     = r_ack[1];
    assign m4_if.ack      = r_ack[2];
    assign o_brightness   = r_act_bright;
    assign o_gamma        = r_act_gamma;
    assign o_ct_red       = r_act_red;
    assign o_ct_green     = r_act_green;
    assign o_ct_blue      = r_act_blue;
    assign o_m4_on        = r_act_m4[0];
    assign o_m4_bank1     = r_act_m4[1];
    assign o_out_ch       = r_act_outch;
    assign o_param_update = r_param_update;
    assign o_dirty        = r_dirty;
    assign o_addr_err     = r_addr_err;

endmodule
